// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - in-order write-back queue in front of the register file with read forwarding
module rf_write_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [4:0]                 in_addr_i,
    input  logic [N-1:0]               in_data_i,
    input  logic                       rf_hold_i,
    output logic                       w_o,
    output logic [4:0]                 da_o,
    output logic [N-1:0]               d_o,
    input  logic [4:0]                 sa_i,
    input  logic [4:0]                 sb_i,
    output logic                       fwd_a_hit_o,
    output logic [N-1:0]               fwd_a_data_o,
    output logic                       fwd_b_hit_o,
    output logic [N-1:0]               fwd_b_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]    addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Writes to XZR are handshaken but never stored.
    assign push = in_valid_i & ~full & (in_addr_i != XZR);
    assign pop  = ~empty & ~rf_hold_i;

    assign in_ready_o = ~full;
    assign empty_o    = empty;
    assign full_o     = full;
    assign count_o    = count_q;

    assign w_o  = pop;
    assign da_o = empty ? 5'd0   : addr_q[rd_ptr_q];
    assign d_o  = empty ? '0     : data_q[rd_ptr_q];

    // Storage, pointers and occupancy; the head is freed on the edge the regfile takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr_i;
                data_q[wr_ptr_q] <= in_data_i;
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk from head to tail so the last match seen is the youngest pending value.
    function automatic logic [N:0] lookup(input logic [4:0] sel);
        logic [N:0]    res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx] == sel) && (sel != XZR)) begin
                res = {1'b1, data_q[idx]};
            end
        end
        return res;
    endfunction

    // Forwarding for both read ports, from stored entries only.
    always_comb begin
        fwd_a_hit_o  = 1'b0;
        fwd_a_data_o = '0;
        fwd_b_hit_o  = 1'b0;
        fwd_b_data_o = '0;
        {fwd_a_hit_o, fwd_a_data_o} = lookup(sa_i);
        {fwd_b_hit_o, fwd_b_data_o} = lookup(sb_i);
    end

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - directed and random checks of rf_write_buffer against a queue model
module tb_rf_write_buffer;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [N-1:0]  in_data;
    logic          rf_hold;
    logic          w;
    logic [4:0]    da;
    logic [N-1:0]  d;
    logic [4:0]    sa, sb;
    logic          fa_hit, fb_hit;
    logic [N-1:0]  fa_data, fb_data;
    logic [2:0]    count;
    logic          empty, full;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]   a;
        logic [N-1:0] d;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    rf_write_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_addr_i(in_addr), .in_data_i(in_data),
        .rf_hold_i(rf_hold),
        .w_o(w), .da_o(da), .d_o(d),
        .sa_i(sa), .sb_i(sb),
        .fwd_a_hit_o(fa_hit), .fwd_a_data_o(fa_data),
        .fwd_b_hit_o(fb_hit), .fwd_b_data_o(fb_data),
        .count_o(count), .empty_o(empty), .full_o(full)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest pending value for a read select, from the model queue.
    task automatic model_fwd(input logic [4:0] sel, output logic hit, output logic [N-1:0] val);
        hit = 1'b0;
        val = '0;
        if (sel != 5'd31) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == sel) begin
                    hit = 1'b1;
                    val = q[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic         eh;
        logic [N-1:0] ed;
        int           sz;
        sz = q.size();
        chk({ph, ".in_ready"}, N'(in_ready), N'(sz < DEPTH));
        chk({ph, ".W"},        N'(w),        N'(sz > 0 && !rf_hold));
        chk({ph, ".DA"},       N'(da),       sz > 0 ? N'(q[0].a) : '0);
        chk({ph, ".D"},        d,            sz > 0 ? q[0].d : '0);
        chk({ph, ".count"},    N'(count),    N'(sz));
        chk({ph, ".empty"},    N'(empty),    N'(sz == 0));
        chk({ph, ".full"},     N'(full),     N'(sz == DEPTH));
        model_fwd(sa, eh, ed);
        chk({ph, ".fwd_a_hit"},  N'(fa_hit), N'(eh));
        chk({ph, ".fwd_a_data"}, fa_data,    ed);
        model_fwd(sb, eh, ed);
        chk({ph, ".fwd_b_hit"},  N'(fb_hit), N'(eh));
        chk({ph, ".fwd_b_data"}, fb_data,    ed);
    endtask

    // One clock: drive at negedge, check mid-low-phase, advance model at posedge.
    task automatic cycle(input string ph, input logic v, input logic [4:0] a, input logic [N-1:0] dat,
                         input logic h, input logic [4:0] s_a, input logic [4:0] s_b);
        int sz;
        in_valid = v; in_addr = a; in_data = dat; rf_hold = h; sa = s_a; sb = s_b;
        #2;
        check_all(ph);
        @(posedge clk);
        sz = q.size();
        if (sz > 0 && !h) void'(q.pop_front());
        if (v && sz < DEPTH && a != 5'd31) q.push_back('{a: a, d: dat});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_addr = 5'd9; in_data = 64'h1234;
        rf_hold = 1'b0; sa = 5'd9; sb = 5'd0;

        // Held in reset with a valid result presented: nothing is taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.in_ready", N'(in_ready), N'(1));
            chk("rst.W",        N'(w),        N'(0));
            chk("rst.count",    N'(count),    N'(0));
            chk("rst.fwd_a",    N'(fa_hit),   N'(0));
        end
        rst_n = 1'b1; in_valid = 1'b0;
        cycle("rel", 0, 5'd9, 64'h0, 0, 5'd9, 5'd0);
        cycle("rel", 0, 5'd9, 64'h0, 0, 5'd9, 5'd0);

        // Single push drains on the following edge.
        cycle("t2", 1, 5'd3, 64'hAAAA, 0, 5'd3, 5'd0);
        chk("t2.DA", N'(da), N'(3));
        chk("t2.D",  d, 64'hAAAA);
        cycle("t2", 0, 5'd0, 64'h0, 0, 5'd3, 5'd0);
        cycle("t2", 0, 5'd0, 64'h0, 0, 5'd3, 5'd0);

        // Fill under hold, stall the fifth push, then drain in order.
        for (int i = 1; i <= 4; i++)
            cycle("t3f", 1, 5'(i), {$urandom, $urandom}, 1, 5'd2, 5'd4);
        cycle("t3s", 1, 5'd5, 64'h55, 1, 5'd2, 5'd4);
        cycle("t3x", 1, 5'd5, 64'h56, 0, 5'd2, 5'd4);
        for (int i = 0; i < 6; i++)
            cycle("t3d", 0, 5'd0, 64'h0, 0, 5'd5, 5'd1);

        // Youngest-wins forwarding for a repeated destination.
        cycle("t4", 1, 5'd5, 64'd11, 1, 5'd5, 5'd6);
        cycle("t4", 1, 5'd5, 64'd22, 1, 5'd5, 5'd6);
        cycle("t4", 0, 5'd0, 64'd0,  1, 5'd5, 5'd6);
        chk("t4.fwd_a_data", fa_data, 64'd22);
        chk("t4.fwd_b_hit",  N'(fb_hit), N'(0));
        for (int i = 0; i < 3; i++)
            cycle("t4d", 0, 5'd0, 64'd0, 0, 5'd5, 5'd6);

        // XZR pushes are accepted and dropped; XZR never forwards.
        cycle("t5", 1, 5'd31, 64'hDEAD, 0, 5'd31, 5'd31);
        cycle("t5", 1, 5'd31, 64'hBEEF, 1, 5'd31, 5'd31);
        cycle("t5", 0, 5'd0,  64'h0,    0, 5'd31, 5'd31);

        // Asynchronous reset with two entries pending.
        cycle("t6", 1, 5'd7, 64'h70, 1, 5'd7, 5'd8);
        cycle("t6", 1, 5'd8, 64'h80, 1, 5'd7, 5'd8);
        in_valid = 1'b0; rf_hold = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.count", N'(count),  N'(0));
        chk("t6.W",     N'(w),      N'(0));
        chk("t6.D",     d,          '0);
        chk("t6.fwd_a", N'(fa_hit), N'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t6r", 0, 5'd7, 64'h0, 0, 5'd7, 5'd8);
        cycle("t6r", 0, 5'd7, 64'h0, 0, 5'd7, 5'd8);

        // Random traffic over a small address range so collisions and fills occur.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            cycle("rnd", 1'($urandom_range(0, 3) != 0), ra, {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
